// File: rtl/rs_pkg.sv
// GF(2^m) helpers shared by the RS encoder, syndrome calculator and Chien search.
package rs_pkg;

  // Default field: GF(2^8) with x^8 + x^4 + x^3 + x^2 + 1, alpha = 2.
  localparam int unsigned SymbolWidthDef = 8;
  localparam logic [8:0]  PrimPolyDef    = 9'h11D;

  // Widest field the helper functions support.
  localparam int unsigned MaxW = 16;

  typedef logic [SymbolWidthDef-1:0] symbol_t;
  typedef logic [MaxW-1:0]           gf_wide_t;
  typedef logic [MaxW:0]             gf_poly_t;

  // Shift-and-reduce multiply in GF(2^m) modulo poly (poly includes the x^m term).
  // Operands and result live in the low m bits of a gf_wide_t.
  function automatic gf_wide_t gf_mul(input gf_wide_t a, input gf_wide_t b,
                                      input int unsigned m, input gf_poly_t poly);
    gf_poly_t p;
    gf_poly_t sh;
    p  = '0;
    sh = {1'b0, a};
    for (int unsigned i = 0; i < MaxW; i++) begin
      if (i < m) begin
        if (b[i]) p = p ^ sh;
        sh = sh << 1;
        if (sh[m]) sh = sh ^ poly;
      end
    end
    return p[MaxW-1:0];
  endfunction

  // alpha^k with alpha = 2; intended for elaboration-time constants only.
  function automatic gf_wide_t gf_alpha_pow(input int unsigned k, input int unsigned m,
                                            input gf_poly_t poly);
    gf_wide_t r;
    r = gf_wide_t'(1);
    for (int unsigned i = 0; i < k; i++) begin
      r = gf_mul(r, gf_wide_t'(2), m, poly);
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_syndrome_cell.sv
// One syndrome accumulator: acc <= acc * alpha^j ^ data (Horner step), or a plain load.
module rs_syndrome_cell
  import rs_pkg::*;
#(
  parameter int unsigned                 SYMBOL_WIDTH = SymbolWidthDef,
  parameter logic [SYMBOL_WIDTH:0]       PRIM_POLY    = PrimPolyDef,
  parameter logic [SYMBOL_WIDTH-1:0]     ALPHA_J      = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_step,
  input  logic                    i_load,
  input  logic                    i_last,
  input  logic [SYMBOL_WIDTH-1:0] i_data,
  output logic [SYMBOL_WIDTH-1:0] o_next
);

  localparam gf_poly_t PolyWide = gf_poly_t'(PRIM_POLY);

  logic [SYMBOL_WIDTH-1:0] r_acc;
  gf_wide_t                w_prod_wide;
  logic [SYMBOL_WIDTH-1:0] w_prod;

  // Constant multiply by alpha^j; synthesis folds the loop into an XOR network.
  always_comb begin
    w_prod_wide = gf_mul(gf_wide_t'(r_acc), gf_wide_t'(ALPHA_J), SYMBOL_WIDTH, PolyWide);
    w_prod      = w_prod_wide[SYMBOL_WIDTH-1:0];
    o_next      = i_load ? i_data : (w_prod ^ i_data);
  end

  // Accumulator; the final value goes to the top-level output register, so clear on last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_step) begin
      r_acc <= i_last ? '0 : o_next;
    end
  end

endmodule

// File: rtl/rs_syndrome_stream.sv
// Streaming RS syndrome calculator with a double-buffered syndrome output register.
module rs_syndrome_stream
  import rs_pkg::*;
#(
  parameter int unsigned           SYMBOL_WIDTH = SymbolWidthDef,
  parameter int unsigned           N            = 18,
  parameter int unsigned           T            = 1,
  parameter logic [SYMBOL_WIDTH:0] PRIM_POLY    = PrimPolyDef
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [SYMBOL_WIDTH-1:0]          in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [2*T*SYMBOL_WIDTH-1:0]      out_syn,
  output logic                             out_error_free
);

  localparam int unsigned NUM_SYN  = 2 * T;
  localparam int unsigned CntW     = $clog2(N);
  localparam gf_poly_t    PolyWide = gf_poly_t'(PRIM_POLY);

  if (SYMBOL_WIDTH < 2 || SYMBOL_WIDTH > MaxW) begin : g_bad_width
    $error("rs_syndrome_stream: SYMBOL_WIDTH out of supported range");
  end
  if (N < 2 || N > (1 << SYMBOL_WIDTH) - 1) begin : g_bad_n
    $error("rs_syndrome_stream: N must satisfy 2 <= N <= 2^SYMBOL_WIDTH-1");
  end
  if (NUM_SYN >= N) begin : g_bad_t
    $error("rs_syndrome_stream: 2T must be less than N");
  end

  logic [CntW-1:0]                 r_count;
  logic [NUM_SYN*SYMBOL_WIDTH-1:0] r_syn;
  logic                            r_out_valid;
  logic                            r_error_free;

  logic                            w_first;
  logic                            w_last;
  logic                            w_accept;
  logic [NUM_SYN*SYMBOL_WIDTH-1:0] w_next;

  // Handshake decode; only the last symbol of a codeword can stall on a full output register.
  always_comb begin
    w_first  = (r_count == '0);
    w_last   = (r_count == CntW'(N - 1));
    in_ready = !(w_last && r_out_valid && !out_ready);
    w_accept = in_valid && in_ready && !flush;
  end

  for (genvar j = 0; j < NUM_SYN; j++) begin : g_cell
    localparam gf_wide_t              AlphaWide = gf_alpha_pow(j + 1, SYMBOL_WIDTH, PolyWide);
    localparam logic [SYMBOL_WIDTH-1:0] AlphaJ  = AlphaWide[SYMBOL_WIDTH-1:0];

    rs_syndrome_cell #(
      .SYMBOL_WIDTH (SYMBOL_WIDTH),
      .PRIM_POLY    (PRIM_POLY),
      .ALPHA_J      (AlphaJ)
    ) u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_step (w_accept),
      .i_load (w_first),
      .i_last (w_last),
      .i_data (in_data),
      .o_next (w_next[j*SYMBOL_WIDTH +: SYMBOL_WIDTH])
    );
  end

  // Symbol counter; flush wins over a same-cycle accept and discards that symbol.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else if (w_accept) begin
      r_count <= w_last ? '0 : r_count + 1'b1;
    end
  end

  // Output register: reload on the last accept (even during a handshake), else drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_syn        <= '0;
      r_out_valid  <= 1'b0;
      r_error_free <= 1'b0;
    end else if (w_accept && w_last) begin
      r_syn        <= w_next;
      r_out_valid  <= 1'b1;
      r_error_free <= (w_next == '0);
    end else if (r_out_valid && out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign out_syn        = r_syn;
  assign out_valid      = r_out_valid;
  assign out_error_free = r_error_free;

endmodule
